// File: rtl/stage_seq_pkg.sv
// Shared definitions for the stage sequencer that drives the FP16 pipe-stage
// datapath: sizing constants, the FSM state type and the packed boundary
// table type.
package stage_seq_pkg;

    localparam int PARA         = 8;                  // step counter / boundary width
    localparam int NUM_STAGES   = 8;                  // boundary-delimited stages per run
    localparam int STAGE_W      = 5;                  // width of the stage index output
    localparam int FINISH_STAGE = NUM_STAGES;         // stage index once a run completes
    localparam int IDX_W        = $clog2(NUM_STAGES); // bits needed to address a boundary

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    // Entry k holds the absolute last step of stage k.
    typedef logic [NUM_STAGES-1:0][PARA-1:0] bound_t;

endpackage

// File: rtl/stage_sequencer_bound_check.sv
// bound_check: combinational check that a boundary table is strictly
// increasing from entry 0 to entry NUM_STAGES-1.
//   i_bound : boundary table to test
//   o_ok    : 1 when every entry is greater than the one before it
module bound_check
    import stage_seq_pkg::*;
(
    input  bound_t i_bound,
    output logic   o_ok
);

    always_comb begin
        o_ok = 1'b1;
        for (int k = 1; k < NUM_STAGES; k++) begin
            if (i_bound[k] <= i_bound[k-1]) begin
                o_ok = 1'b0;
            end
        end
    end

endmodule

// File: rtl/stage_sequencer.sv
// stage_sequencer: produces the stage index, step count, mode flag and
// reduction-clear pulse for the FP16 pipe-stage datapath. A run is launched
// with start, walks through NUM_STAGES stages whose last steps come from a
// boundary table latched at launch, can be stalled with en and cancelled with
// abort, and ends with a one-cycle done pulse.
//
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   start       : launch a run (only looked at while idle)
//   abort       : cancel a run in progress
//   en          : advance enable; low freezes step and stage
//   bound_i     : packed boundary table, slice k = last step of stage k
//   clr_mask_i  : bit k requests a reduction clear when stage k ends
//   stage, step : current stage index and absolute step within the run
//   mode        : high while busy in stage 0 or 1
//   red_clr     : one-cycle reduction-tree clear
//   busy, done  : run in progress / one-cycle completion pulse
//   finished    : stage has reached NUM_STAGES
//   cfg_err     : one-cycle pulse when a start is rejected
module stage_sequencer
    import stage_seq_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       abort,
    input  logic                       en,
    input  logic [NUM_STAGES*PARA-1:0] bound_i,
    input  logic [NUM_STAGES-1:0]      clr_mask_i,
    output logic [STAGE_W-1:0]         stage,
    output logic [PARA-1:0]            step,
    output logic                       mode,
    output logic                       red_clr,
    output logic                       busy,
    output logic                       done,
    output logic                       finished,
    output logic                       cfg_err
);

    state_e                  r_state,   w_state_nx;
    logic [STAGE_W-1:0]      r_stage,   w_stage_nx;
    logic [PARA-1:0]         r_step,    w_step_nx;
    logic                    r_mode,    w_mode_nx;
    logic                    r_red_clr, w_red_clr_nx;
    logic                    r_done,    w_done_nx;
    logic                    r_cfg_err, w_cfg_err_nx;
    bound_t                  r_bound,   w_bound_nx;
    logic [NUM_STAGES-1:0]   r_mask,    w_mask_nx;

    bound_t                  w_bound_in;
    logic                    w_cfg_ok;
    logic [IDX_W-1:0]        w_idx;
    logic                    w_at_bound;
    logic                    w_last_stage;

    assign w_bound_in = bound_i;

    bound_check u_bound_check (
        .i_bound (w_bound_in),
        .o_ok    (w_cfg_ok)
    );

    // While running, stage never exceeds NUM_STAGES-1, so the low bits index
    // the boundary table directly.
    assign w_idx        = r_stage[IDX_W-1:0];
    assign w_at_bound   = (r_step == r_bound[w_idx]);
    assign w_last_stage = (r_stage == STAGE_W'(NUM_STAGES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_stage   <= '0;
            r_step    <= '0;
            r_mode    <= 1'b0;
            r_red_clr <= 1'b0;
            r_done    <= 1'b0;
            r_cfg_err <= 1'b0;
            r_bound   <= '0;
            r_mask    <= '0;
        end else begin
            r_state   <= w_state_nx;
            r_stage   <= w_stage_nx;
            r_step    <= w_step_nx;
            r_mode    <= w_mode_nx;
            r_red_clr <= w_red_clr_nx;
            r_done    <= w_done_nx;
            r_cfg_err <= w_cfg_err_nx;
            r_bound   <= w_bound_nx;
            r_mask    <= w_mask_nx;
        end
    end

    always_comb begin
        w_state_nx   = r_state;
        w_stage_nx   = r_stage;
        w_step_nx    = r_step;
        w_red_clr_nx = 1'b0;
        w_done_nx    = 1'b0;
        w_cfg_err_nx = 1'b0;
        w_bound_nx   = r_bound;
        w_mask_nx    = r_mask;

        case (r_state)
            IDLE: begin
                // abort is meaningless here, so start is handled even if both are high.
                if (start) begin
                    if (w_cfg_ok) begin
                        w_bound_nx = w_bound_in;
                        w_mask_nx  = clr_mask_i;
                        w_stage_nx = '0;
                        w_step_nx  = '0;
                        w_state_nx = RUN;
                    end else begin
                        w_cfg_err_nx = 1'b1;
                    end
                end
            end
            RUN: begin
                if (abort) begin
                    w_stage_nx = '0;
                    w_step_nx  = '0;
                    w_state_nx = IDLE;
                end else if (en) begin
                    w_step_nx = r_step + 1'b1;
                    if (w_at_bound) begin
                        w_stage_nx   = r_stage + 1'b1;
                        w_red_clr_nx = r_mask[w_idx];
                        if (w_last_stage) begin
                            w_state_nx = IDLE;
                            w_done_nx  = 1'b1;
                        end
                    end
                end
            end
            default: begin
                w_state_nx = IDLE;
            end
        endcase

        // Registered alongside stage so mode and stage change on the same edge.
        w_mode_nx = (w_state_nx == RUN) && (w_stage_nx < STAGE_W'(2));
    end

    assign stage    = r_stage;
    assign step     = r_step;
    assign mode     = r_mode;
    assign red_clr  = r_red_clr;
    assign busy     = (r_state == RUN);
    assign done     = r_done;
    assign finished = (r_stage == STAGE_W'(FINISH_STAGE));
    assign cfg_err  = r_cfg_err;

endmodule

// File: tb/tb_stage_sequencer.sv
// Bench for stage_sequencer: a run-level model (step count plus the latched
// boundary table; stage is derived as the number of boundaries already passed)
// is checked against the DUT on every falling edge, and directed scenarios pin
// hand-computed values at specific cycles.
module tb_stage_sequencer;
    import stage_seq_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        en = 1'b1;
    logic [63:0] bound_i = '0;
    logic [7:0]  clr_mask_i = 8'h72;
    logic [4:0]  stage;
    logic [7:0]  step;
    logic        mode, red_clr, busy, done, finished, cfg_err;

    int checks = 0;
    int failures = 0;

    int good_b[8] = '{3, 7, 11, 15, 19, 23, 27, 31};
    int bad_b[8]  = '{3, 7, 11, 11, 19, 23, 27, 31};

    // Run-level model state.
    int       m_step = 0;
    bit       m_busy = 1'b0;
    bit       m_done = 1'b0;
    bit       m_red = 1'b0;
    bit       m_cfg = 1'b0;
    int       m_b[8] = '{0, 0, 0, 0, 0, 0, 0, 0};
    bit [7:0] m_mask = '0;

    stage_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .en         (en),
        .bound_i    (bound_i),
        .clr_mask_i (clr_mask_i),
        .stage      (stage),
        .step       (step),
        .mode       (mode),
        .red_clr    (red_clr),
        .busy       (busy),
        .done       (done),
        .finished   (finished),
        .cfg_err    (cfg_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] pack(input int b[8]);
        logic [63:0] v;
        v = '0;
        for (int k = 0; k < 8; k++) v[k*8 +: 8] = 8'(b[k]);
        return v;
    endfunction

    function automatic bit increasing(input logic [63:0] v);
        for (int k = 1; k < 8; k++)
            if (v[k*8 +: 8] <= v[(k-1)*8 +: 8]) return 1'b0;
        return 1'b1;
    endfunction

    // Stage = how many stage boundaries lie strictly below the current step.
    function automatic int stage_of(input int s);
        int n;
        n = 0;
        for (int k = 0; k < 8; k++) if (m_b[k] < s) n++;
        return n;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_step <= 0;
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_red  <= 1'b0;
            m_cfg  <= 1'b0;
            m_b    <= '{0, 0, 0, 0, 0, 0, 0, 0};
            m_mask <= '0;
        end else begin
            automatic int n_step = m_step;
            automatic bit n_busy = m_busy;
            automatic bit n_done = 1'b0;
            automatic bit n_red = 1'b0;
            automatic bit n_cfg = 1'b0;
            automatic int old_s = stage_of(m_step);
            automatic int new_s;
            if (!m_busy) begin
                if (start) begin
                    if (increasing(bound_i)) begin
                        for (int k = 0; k < 8; k++) m_b[k] <= int'(bound_i[k*8 +: 8]);
                        m_mask <= clr_mask_i;
                        n_busy = 1'b1;
                        n_step = 0;
                    end else begin
                        n_cfg = 1'b1;
                    end
                end
            end else if (abort) begin
                n_busy = 1'b0;
                n_step = 0;
            end else if (en) begin
                n_step = m_step + 1;
                new_s = stage_of(n_step);
                if (new_s != old_s) n_red = m_mask[old_s];
                if (new_s == 8) begin
                    n_busy = 1'b0;
                    n_done = 1'b1;
                end
            end
            m_step <= n_step;
            m_busy <= n_busy;
            m_done <= n_done;
            m_red  <= n_red;
            m_cfg  <= n_cfg;
        end
    end

    // Model comparison on every falling edge.
    always @(negedge clk) begin
        automatic int es = stage_of(m_step);
        chk("m_stage", 32'(stage), 32'(es));
        chk("m_step", 32'(step), 32'(m_step));
        chk("m_busy", 32'(busy), 32'(m_busy));
        chk("m_done", 32'(done), 32'(m_done));
        chk("m_red_clr", 32'(red_clr), 32'(m_red));
        chk("m_cfg_err", 32'(cfg_err), 32'(m_cfg));
        chk("m_mode", 32'(mode), 32'(m_busy && es < 2));
        chk("m_finished", 32'(finished), 32'(es == 8));
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic launch();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        bound_i = pack(good_b);
        cyc(2);
        chk("rst_stage", 32'(stage), 0);
        chk("rst_step", 32'(step), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_mode", 32'(mode), 0);
        chk("rst_finished", 32'(finished), 0);
        chk("rst_flags", {red_clr, done, cfg_err}, 0);
        rst = 1'b0;
        cyc(1);

        // Rejected configuration: bound[3] equals bound[2].
        bound_i = pack(bad_b);
        launch();
        chk("bad_cfg_err", 32'(cfg_err), 1);
        chk("bad_busy", 32'(busy), 0);
        chk("bad_stage", 32'(stage), 0);
        chk("bad_done", 32'(done), 0);
        cyc(1);
        chk("bad_cfg_pulse", 32'(cfg_err), 0);
        bound_i = pack(good_b);

        // Normal run.
        launch();
        chk("run_busy", 32'(busy), 1);
        chk("run_step0", 32'(step), 0);
        chk("run_mode0", 32'(mode), 1);
        cyc(4);
        chk("run_stage1", 32'(stage), 1);
        chk("run_red_s4", 32'(red_clr), 0);
        chk("run_mode_s4", 32'(mode), 1);
        cyc(4);
        chk("run_stage2", 32'(stage), 2);
        chk("run_red_s8", 32'(red_clr), 1);
        chk("run_mode_s8", 32'(mode), 0);
        cyc(12);
        chk("run_stage5", 32'(stage), 5);
        chk("run_red_s20", 32'(red_clr), 1);
        cyc(12);
        chk("run_done", 32'(done), 1);
        chk("run_stage8", 32'(stage), 8);
        chk("run_finished", 32'(finished), 1);
        chk("run_busy_end", 32'(busy), 0);
        chk("run_step_end", 32'(step), 32);
        cyc(1);
        chk("run_done_pulse", 32'(done), 0);
        chk("run_finished_hold", 32'(finished), 1);

        // abort while idle has no effect.
        abort = 1'b1;
        cyc(1);
        abort = 1'b0;
        chk("idle_abort_stage", 32'(stage), 8);
        chk("idle_abort_step", 32'(step), 32);

        // Stall for 5 cycles at step 9 (stage 2).
        launch();
        cyc(9);
        chk("stall_step", 32'(step), 9);
        chk("stall_stage", 32'(stage), 2);
        en = 1'b0;
        cyc(5);
        chk("stall_step_hold", 32'(step), 9);
        chk("stall_stage_hold", 32'(stage), 2);
        chk("stall_red", 32'(red_clr), 0);
        en = 1'b1;
        cyc(22);
        chk("stall_done_early", 32'(done), 0);
        cyc(1);
        chk("stall_done", 32'(done), 1);

        // Abort at step 13, with start also high: abort wins.
        launch();
        cyc(13);
        chk("abort_pre_step", 32'(step), 13);
        chk("abort_pre_stage", 32'(stage), 3);
        abort = 1'b1;
        start = 1'b1;
        cyc(1);
        abort = 1'b0;
        start = 1'b0;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_stage", 32'(stage), 0);
        chk("abort_step", 32'(step), 0);
        chk("abort_done", 32'(done), 0);
        // Idle start with abort also high: start is taken.
        abort = 1'b1;
        launch();
        abort = 1'b0;
        chk("restart_busy", 32'(busy), 1);
        chk("restart_step", 32'(step), 0);
        cyc(32);
        chk("restart_done", 32'(done), 1);
        chk("restart_stage", 32'(stage), 8);

        // Start while busy is ignored, even with a bad table presented.
        launch();
        cyc(5);
        bound_i = pack(bad_b);
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        bound_i = pack(good_b);
        chk("ign_cfg_err", 32'(cfg_err), 0);
        chk("ign_busy", 32'(busy), 1);
        chk("ign_step", 32'(step), 6);
        cyc(11);
        chk("rst_mid_step", 32'(step), 17);
        chk("rst_mid_stage", 32'(stage), 4);
        #2 rst = 1'b1;
        #1;
        chk("arst_stage", 32'(stage), 0);
        chk("arst_step", 32'(step), 0);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_mode", 32'(mode), 0);
        chk("arst_flags", {red_clr, done, cfg_err, finished}, 0);
        cyc(1);
        rst = 1'b0;
        cyc(1);
        launch();
        chk("fresh_busy", 32'(busy), 1);
        chk("fresh_step", 32'(step), 0);
        chk("fresh_stage", 32'(stage), 0);
        cyc(32);
        chk("fresh_done", 32'(done), 1);
        chk("fresh_stage8", 32'(stage), 8);

        cyc(1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
